ifu_axi_lite_rd: RTL and testbench
==================================

# ifu_axi_lite_rd

Instruction-fetch AXI4-Lite read master sitting directly upstream of the fetch stage. It accepts a single-word fetch request (start level plus 64-bit PC) and performs one AXI4-Lite read burst (AR then R) toward instruction memory. It returns the selected 32-bit instruction with a one-cycle finish pulse. Exactly one transaction is outstanding at a time.

## Interface
- ADDR_W, 32: AXI address width; `araddr = PC_addr[ADDR_W-1:0]`.
- DATA_W, 64: AXI read data width; fixed at 64 in this revision.
- TIMEOUT_CYC, 1024: cycles before a hung transaction is aborted; used only when `IFU_AXI_TIMEOUT_EN` is defined.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- read_instr_start  in  1  fetch request level from the fetch stage.
- PC_addr  in  64  fetch address; stable while start is high.
- read_instr_finish  out  1  one-cycle pulse; the fetch has completed.
- INSTR_READ  out  32  instruction; valid only while finish is high.
- fetch_err  out  1  pulses together with finish when the fetch failed.
- araddr  out  ADDR_W  AXI read address.
- arprot  out  3  constant `3'b100` (instruction, secure, unprivileged).
- arvalid  out  1  AXI address valid.
- arready  in  1  AXI address ready.
- rdata  in  DATA_W  AXI read data.
- rresp  in  2  AXI read response.
- rvalid  in  1  AXI read valid.
- rready  out  1  AXI read ready.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE. All outputs are registered or decoded from state only, with no combinational path from AXI inputs to outputs.
- IDLE: when `read_instr_start` is high, latch `PC_addr` into `addr_q` and go to ADDR.
- ADDR: `arvalid=1` and `araddr=addr_q[ADDR_W-1:0]`. On `arready`, go to DATA. `araddr` is held stable until the handshake completes.
- DATA: `rready=1`. On `rvalid`, capture data and set `err_q = (rresp != 2'b00) | (addr_q[1:0] != 0)`, then go to DATA's successor, DONE.
- DONE (one cycle): `read_instr_finish=1` and `fetch_err=err_q`. Then unconditionally return to IDLE.
- Word select: `INSTR_READ = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]`.
- On error, `INSTR_READ = 32'h0010_0073` (ebreak) so the simulation traps.
- Misaligned PC (`addr_q[1:0] != 0`): the AXI read is still issued, and the fetch is reported as an error.
- Requester contract: the fetch stage deasserts start on the edge at which it samples finish. DONE→IDLE therefore never relaunches on a stale start.
- If start is still high in IDLE, a new fetch launches. Back-to-back fetches are legal.
- Start dropping during ADDR or DATA is ignored; the transaction completes.

## Timing
- Reset values: `arvalid=0`, `rready=0`, `read_instr_finish=0`, `fetch_err=0`, `INSTR_READ=0`, `araddr=0`, state IDLE, `addr_q=0`, `rdata_q=0`, timeout counter 0.
- Reset mid-transaction: return to IDLE next cycle with `arvalid` and `rready` low. Any in-flight slave response is discarded by the interconnect/slave reset.
- Minimum latency, when `arready` and `rvalid` are high on first assertion:
  - start sampled at edge 0;
  - ADDR in cycle 1;
  - DATA in cycle 2;
  - finish in cycle 3.
- Each slave stall cycle adds one cycle.
- `rvalid` arriving early, before DATA, is not sampled. `rready` is low outside DATA.
- finish is high for exactly one cycle per transaction, never two consecutive cycles.

## Configuration
- `IFU_AXI_TIMEOUT_EN` defined:
  - a counter clears on IDLE→ADDR and increments each cycle in ADDR or DATA;
  - on reaching `TIMEOUT_CYC-1`, go to DONE with `err_q=1`;
  - `arvalid` and `rready` drop. This is a deliberate protocol abort, used only as a debug aid.
- Not defined: no counter; the FSM waits indefinitely in ADDR/DATA.

## Structure
- Package `ifu_axi_pkg` holds:
  - the state enum `ifu_rd_state_t`;
  - `AXI_RESP_OKAY = 2'b00`;
  - `ARPROT_IFETCH = 3'b100`;
  - `INSTR_EBREAK = 32'h0010_0073`.
- Sub-module `ifu_axi_timeout`: a counter with clear/enable/expire ports, instantiated only under `IFU_AXI_TIMEOUT_EN`.

## Test plan
- Zero-wait slave; `PC=64'h8000_0000`; `rdata=64'h1111_1111_0000_0513` → `araddr=32'h8000_0000`, finish in cycle 3, `INSTR_READ=32'h0000_0513`, `fetch_err=0`.
- `PC=64'h8000_0004`; same rdata; `arready` delayed 2 cycles and `rvalid` delayed 3 cycles → `INSTR_READ=32'h1111_1111`, finish in cycle 8, `araddr` stable throughout ADDR.
- `rresp=2'b10` (SLVERR) → finish with `fetch_err=1` and `INSTR_READ=32'h0010_0073`.
- `PC=64'h8000_0002` → AXI read issued; finish with `fetch_err=1` and `INSTR_READ=32'h0010_0073`.
- `rst` asserted in DATA → next cycle IDLE with `rready=0`, no finish pulse; a following fetch after reset completes normally.
- With `IFU_AXI_TIMEOUT_EN` and `TIMEOUT_CYC=16`: `arready` held low → finish with `fetch_err=1` after 16 ADDR cycles, then `arvalid=0`.

Source files
------------

// File: rtl/ifu_axi_pkg.sv
// Shared types and constants for the instruction-fetch AXI4-Lite read master.
package ifu_axi_pkg;

  // Fetch FSM states: launch address, wait for data, report result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } ifu_rd_state_t;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  // Instruction access, secure, unprivileged.
  localparam logic [2:0]  ARPROT_IFETCH = 3'b100;
  // Returned on any failed fetch so the core traps.
  localparam logic [31:0] INSTR_EBREAK  = 32'h0010_0073;

endpackage

// File: rtl/ifu_axi_timeout.sv
// Cycle counter for aborting a hung fetch. Clears on clr, counts while en,
// and flags expire once the count reaches TIMEOUT_CYC-1.
module ifu_axi_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Counter: clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ifu_axi_lite_rd.sv
// Instruction-fetch AXI4-Lite read master: one single-word read per fetch
// request, one transaction outstanding at a time.
// Optional feature macro: IFU_AXI_TIMEOUT_EN (aborts a hung AR/R wait after
// TIMEOUT_CYC cycles and reports a fetch error).
//
// Handshake: a channel transfers on the rising edge where valid and ready are
// both high; arvalid is held with a stable araddr until arready is seen, and
// rready is only high in the DATA state so early rvalid is never sampled.
module ifu_axi_lite_rd
  import ifu_axi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_instr_start,
  input  logic [63:0]       PC_addr,
  output logic              read_instr_finish,
  output logic [31:0]       INSTR_READ,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output ifu_rd_state_t     state_dbg
);

  ifu_rd_state_t     state;
  logic [63:0]       addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              timeout_exp;
  logic              data_err;

  assign arprot    = ARPROT_IFETCH;
  assign araddr    = addr_q[ADDR_W-1:0];
  assign state_dbg = state;
  assign data_err  = (rresp != AXI_RESP_OKAY) || (addr_q[1:0] != 2'b00);

`ifdef IFU_AXI_TIMEOUT_EN
  ifu_axi_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .en     ((state == ST_ADDR) || (state == ST_DATA)),
    .expire (timeout_exp)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_exp        = 1'b0;
`endif

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[63:ADDR_W];

  // Fetch FSM with registered AXI controls and finish/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      addr_q            <= '0;
      rdata_q           <= '0;
      err_q             <= 1'b0;
      arvalid           <= 1'b0;
      rready            <= 1'b0;
      read_instr_finish <= 1'b0;
      fetch_err         <= 1'b0;
    end else begin
      read_instr_finish <= 1'b0;
      fetch_err         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read_instr_start) begin
            addr_q  <= PC_addr;
            arvalid <= 1'b1;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_DATA;
          end else if (timeout_exp) begin
            arvalid           <= 1'b0;
            err_q             <= 1'b1;
            read_instr_finish <= 1'b1;
            fetch_err         <= 1'b1;
            state             <= ST_DONE;
          end
        end
        ST_DATA: begin
          if (rvalid) begin
            rdata_q           <= rdata;
            err_q             <= data_err;
            rready            <= 1'b0;
            read_instr_finish <= 1'b1;
            fetch_err         <= data_err;
            state             <= ST_DONE;
          end else if (timeout_exp) begin
            rready            <= 1'b0;
            err_q             <= 1'b1;
            read_instr_finish <= 1'b1;
            fetch_err         <= 1'b1;
            state             <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The requester drops start as it samples finish, so no relaunch here.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Instruction word select from registered state; ebreak on error, 0 when idle.
  always_comb begin
    INSTR_READ = 32'h0;
    if (read_instr_finish) begin
      if (err_q) INSTR_READ = INSTR_EBREAK;
      else       INSTR_READ = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
    end
  end

endmodule

// File: tb/tb_ifu_axi_lite_rd.sv
// Directed testbench for ifu_axi_lite_rd with an inline AXI4-Lite slave driver.
module tb_ifu_axi_lite_rd;
  import ifu_axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              read_instr_start;
  logic [63:0]       PC_addr;
  logic              read_instr_finish;
  logic [31:0]       INSTR_READ;
  logic              fetch_err;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  ifu_rd_state_t     state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_axi_lite_rd #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
`ifdef IFU_AXI_TIMEOUT_EN
    .TIMEOUT_CYC (16)
`else
    .TIMEOUT_CYC (1024)
`endif
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .read_instr_start  (read_instr_start),
    .PC_addr           (PC_addr),
    .read_instr_finish (read_instr_finish),
    .INSTR_READ        (INSTR_READ),
    .fetch_err         (fetch_err),
    .araddr            (araddr),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rdata             (rdata),
    .rresp             (rresp),
    .rvalid            (rvalid),
    .rready            (rready),
    .state_dbg         (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one fetch, model a slave with ar_wait/r_wait stall cycles.
  // fin_cyc counts cycles after the edge that sampled start (-1 = none).
  task automatic do_fetch(input logic [63:0] pc, input logic [63:0] data,
                          input logic [1:0] resp, input int ar_wait, input int r_wait,
                          output int fin_cyc, output logic [31:0] instr,
                          output logic err, output logic [31:0] ar_seen,
                          output logic ar_stable, output logic fin_after);
    int cyc;
    int ar_cnt;
    int r_cnt;
    logic [31:0] prev;
    read_instr_start = 1'b1;
    PC_addr          = pc;
    arready          = 1'b0;
    rvalid           = 1'b0;
    tick();
    read_instr_start = 1'b0;
    cyc = 1; ar_cnt = 0; r_cnt = 0; fin_cyc = -1;
    instr = 32'h0; err = 1'b0; ar_seen = 32'h0; ar_stable = 1'b1; prev = 32'h0;
    fin_after = 1'b0;
    while (cyc < 200) begin
      if (read_instr_finish) begin
        fin_cyc = cyc;
        instr   = INSTR_READ;
        err     = fetch_err;
        break;
      end
      if (arvalid) begin
        if (ar_cnt > 0 && araddr !== prev) ar_stable = 1'b0;
        prev    = araddr;
        ar_seen = araddr;
        arready = (ar_cnt == ar_wait);
        ar_cnt++;
      end else begin
        arready = 1'b0;
      end
      if (rready) begin
        rdata  = data;
        rresp  = resp;
        rvalid = (r_cnt == r_wait);
        r_cnt++;
      end else begin
        rvalid = 1'b0;
      end
      tick();
      cyc++;
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    tick();
    fin_after = read_instr_finish;
  endtask

  task automatic test_reset();
    rst = 1'b1; read_instr_start = 1'b0; PC_addr = 64'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    repeat (3) tick();
    n_tests++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got=%b exp=0", rready); end
    n_tests++; if (read_instr_finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got=%b exp=0", read_instr_finish); end
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
    n_tests++; if (INSTR_READ !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", INSTR_READ); end
    n_tests++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr got=%h exp=0", araddr); end
    n_tests++; if (arprot !== 3'b100) begin n_fail++; $display("FAIL reset_arprot got=%b exp=100", arprot); end
    rst = 1'b0;
    tick();
    n_tests++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_zero_wait();
    int fc; logic [31:0] ins; logic e; logic [31:0] aa; logic st; logic fa;
    do_fetch(64'h8000_0000, 64'h1111_1111_0000_0513, 2'b00, 0, 0, fc, ins, e, aa, st, fa);
    n_tests++; if (aa !== 32'h8000_0000) begin n_fail++; $display("FAIL zw_araddr got=%h exp=80000000", aa); end
    n_tests++; if (fc !== 3) begin n_fail++; $display("FAIL zw_latency got=%0d exp=3", fc); end
    n_tests++; if (ins !== 32'h0000_0513) begin n_fail++; $display("FAIL zw_instr got=%h exp=00000513", ins); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL zw_err got=%b exp=0", e); end
    n_tests++; if (fa !== 1'b0) begin n_fail++; $display("FAIL zw_finish_twice got=%b exp=0", fa); end
    n_tests++; if (INSTR_READ !== 32'h0) begin n_fail++; $display("FAIL zw_instr_idle got=%h exp=0", INSTR_READ); end
  endtask

  task automatic test_stall();
    int fc; logic [31:0] ins; logic e; logic [31:0] aa; logic st; logic fa;
    do_fetch(64'h8000_0004, 64'h1111_1111_0000_0513, 2'b00, 2, 3, fc, ins, e, aa, st, fa);
    n_tests++; if (fc !== 8) begin n_fail++; $display("FAIL stall_latency got=%0d exp=8", fc); end
    n_tests++; if (ins !== 32'h1111_1111) begin n_fail++; $display("FAIL stall_instr got=%h exp=11111111", ins); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL stall_err got=%b exp=0", e); end
    n_tests++; if (st !== 1'b1 || aa !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_araddr got=%h stable=%b exp=80000004 stable=1", aa, st); end
    n_tests++; if (fa !== 1'b0) begin n_fail++; $display("FAIL stall_finish_twice got=%b exp=0", fa); end
  endtask

  task automatic test_slverr();
    int fc; logic [31:0] ins; logic e; logic [31:0] aa; logic st; logic fa;
    do_fetch(64'h8000_0000, 64'h1111_1111_0000_0513, 2'b10, 0, 1, fc, ins, e, aa, st, fa);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL slverr_err got=%b exp=1", e); end
    n_tests++; if (ins !== 32'h0010_0073) begin n_fail++; $display("FAIL slverr_instr got=%h exp=00100073", ins); end
    n_tests++; if (fc !== 4) begin n_fail++; $display("FAIL slverr_latency got=%0d exp=4", fc); end
  endtask

  task automatic test_misaligned();
    int fc; logic [31:0] ins; logic e; logic [31:0] aa; logic st; logic fa;
    do_fetch(64'h8000_0002, 64'h1111_1111_0000_0513, 2'b00, 1, 0, fc, ins, e, aa, st, fa);
    n_tests++; if (aa !== 32'h8000_0002) begin n_fail++; $display("FAIL misal_araddr got=%h exp=80000002", aa); end
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL misal_err got=%b exp=1", e); end
    n_tests++; if (ins !== 32'h0010_0073) begin n_fail++; $display("FAIL misal_instr got=%h exp=00100073", ins); end
    n_tests++; if (fc !== 4) begin n_fail++; $display("FAIL misal_latency got=%0d exp=4", fc); end
  endtask

  task automatic test_reset_mid();
    int fc; logic [31:0] ins; logic e; logic [31:0] aa; logic st; logic fa;
    read_instr_start = 1'b1; PC_addr = 64'h8000_0100; arready = 1'b0; rvalid = 1'b0;
    tick();
    read_instr_start = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_data got=%b exp=1", rready); end
    rst = 1'b1;
    tick();
    n_tests++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    n_tests++; if (rready !== 1'b0 || arvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got=rready %b arvalid %b exp=0 0", rready, arvalid); end
    n_tests++; if (read_instr_finish !== 1'b0) begin n_fail++; $display("FAIL rstmid_finish got=%b exp=0", read_instr_finish); end
    rst = 1'b0;
    tick();
    n_tests++; if (read_instr_finish !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_pulse got=%b exp=0", read_instr_finish); end
    do_fetch(64'h8000_0008, 64'hdead_beef_cafe_f00d, 2'b00, 0, 0, fc, ins, e, aa, st, fa);
    n_tests++; if (ins !== 32'hcafe_f00d || e !== 1'b0 || fc !== 3) begin n_fail++; $display("FAIL rstmid_refetch got=%h err=%b cyc=%0d exp=cafef00d err=0 cyc=3", ins, e, fc); end
  endtask

  task automatic test_back_to_back();
    int fc; logic [31:0] ins; logic e; logic [31:0] aa; logic st; logic fa;
    do_fetch(64'h8000_000c, 64'haaaa_bbbb_cccc_dddd, 2'b00, 0, 0, fc, ins, e, aa, st, fa);
    n_tests++; if (ins !== 32'haaaa_bbbb || e !== 1'b0) begin n_fail++; $display("FAIL b2b_first got=%h err=%b exp=aaaabbbb err=0", ins, e); end
    do_fetch(64'h8000_0010, 64'h0123_4567_89ab_cdef, 2'b00, 1, 2, fc, ins, e, aa, st, fa);
    n_tests++; if (ins !== 32'h89ab_cdef || e !== 1'b0) begin n_fail++; $display("FAIL b2b_second got=%h err=%b exp=89abcdef err=0", ins, e); end
    n_tests++; if (fc !== 6) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=6", fc); end
    n_tests++; if (aa !== 32'h8000_0010) begin n_fail++; $display("FAIL b2b_araddr got=%h exp=80000010", aa); end
  endtask

`ifdef IFU_AXI_TIMEOUT_EN
  task automatic test_timeout();
    int fc; logic [31:0] ins; logic e; logic [31:0] aa; logic st; logic fa;
    do_fetch(64'h8000_0020, 64'h0, 2'b00, 1000, 0, fc, ins, e, aa, st, fa);
    n_tests++; if (fc !== 17) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=17", fc); end
    n_tests++; if (e !== 1'b1 || ins !== 32'h0010_0073) begin n_fail++; $display("FAIL timeout_err got=%b instr=%h exp=1 00100073", e, ins); end
    n_tests++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL timeout_arvalid got=%b exp=0", arvalid); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_slverr();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
`ifdef IFU_AXI_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
